pipelined_vector_adder: RTL and testbench



---
 rtl/pipelined_vector_adder.sv | 157 +++++++++++++++
 tb/tb_pipelined_vector_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_vector_adder.sv
// rtl/pipelined_vector_adder.sv - carry-pipelined WIDTH-bit adder, one segment per stage, 1/2/4 lanes
module pipelined_vector_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_carry,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_carry
);

  localparam int SEG = WIDTH / STAGES;

  logic en;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  function automatic int lane_w(input logic [1:0] m);
    case (m)
      2'b01:   return WIDTH / 2;
      2'b10:   return WIDTH / 4;
      default: return WIDTH;
    endcase
  endfunction

  function automatic logic [1:0] lane_of(input int i, input logic [1:0] m);
    return 2'(i / lane_w(m));
  endfunction

  // Ripples segment s; a lane's LSB always takes that lane's own carry-in.
  function automatic logic [WIDTH+3:0] add_seg(input int s, input logic [WIDTH-1:0] acc,
                                               input logic [SEG-1:0] b, input logic [1:0] m,
                                               input logic [3:0] cin, input logic [3:0] co,
                                               input logic c_in);
    logic [WIDTH-1:0] r;
    logic [3:0]       cr;
    logic             c, x, y;
    int               i;
    r  = acc;
    cr = co;
    c  = c_in;
    for (int j = 0; j < SEG; j++) begin
      i = s * SEG + j;
      if (i % lane_w(m) == 0) c = cin[lane_of(i, m)];
      x    = acc[i];
      y    = b[j];
      r[i] = x ^ y ^ c;
      c    = (x & y) | (x & c) | (y & c);
      if (i % lane_w(m) == lane_w(m) - 1) cr[lane_of(i, m)] = c;
    end
    return {cr, r};
  endfunction

  function automatic logic seg_cout(input int s, input logic [WIDTH-1:0] acc,
                                    input logic [SEG-1:0] b, input logic [1:0] m,
                                    input logic [3:0] cin, input logic c_in);
    logic c, x, y;
    int   i;
    c = c_in;
    for (int j = 0; j < SEG; j++) begin
      i = s * SEG + j;
      if (i % lane_w(m) == 0) c = cin[lane_of(i, m)];
      x = acc[i];
      y = b[j];
      c = (x & y) | (x & c) | (y & c);
    end
    return c;
  endfunction

  // acc carries finished sum bits below the current segment and still-pending A bits above it.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             v_d, v_q;
    logic [WIDTH-1:0] acc_d, acc_q;
    logic [SEG-1:0]   b_seg;
    logic [1:0]       m_d;
    logic [3:0]       ci_d, co_d, co_q;
    logic             c_d;
    logic [WIDTH+3:0] nxt;

    if (s == 0) begin : g_src
      assign v_d   = in_valid;
      assign acc_d = in_a;
      assign b_seg = in_b[SEG-1:0];
      assign m_d   = (in_mode == 2'b11) ? 2'b00 : in_mode;
      assign ci_d  = in_carry;
      assign co_d  = 4'b0000;
      assign c_d   = 1'b0;
    end else begin : g_src
      assign v_d   = g_stage[s-1].v_q;
      assign acc_d = g_stage[s-1].acc_q;
      assign b_seg = g_stage[s-1].g_fwd.b_q[SEG-1:0];
      assign m_d   = g_stage[s-1].g_fwd.m_q;
      assign ci_d  = g_stage[s-1].g_fwd.ci_q;
      assign co_d  = g_stage[s-1].co_q;
      assign c_d   = g_stage[s-1].g_fwd.c_q;
    end

    assign nxt = add_seg(s, acc_d, b_seg, m_d, ci_d, co_d, c_d);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        acc_q <= '0;
        co_q  <= '0;
      end else if (en) begin
        v_q <= v_d;
        if (v_d) begin
          acc_q <= nxt[WIDTH-1:0];
          co_q  <= nxt[WIDTH+3:WIDTH];
        end
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      localparam int BW = WIDTH - (s + 1) * SEG;

      logic [BW-1:0] b_hi, b_q;
      logic [1:0]    m_q;
      logic [3:0]    ci_q;
      logic          c_q;

      if (s == 0) begin : g_bsrc
        assign b_hi = in_b[WIDTH-1:SEG];
      end else begin : g_bsrc
        assign b_hi = g_stage[s-1].g_fwd.b_q[WIDTH-s*SEG-1:SEG];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q  <= '0;
          m_q  <= 2'b00;
          ci_q <= 4'b0000;
          c_q  <= 1'b0;
        end else if (en && v_d) begin
          b_q  <= b_hi;
          m_q  <= m_d;
          ci_q <= ci_d;
          c_q  <= seg_cout(s, acc_d, b_seg, m_d, ci_d, c_d);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign out_sum   = g_stage[STAGES-1].acc_q;
  assign out_carry = g_stage[STAGES-1].co_q;

endmodule

// File: tb/tb_pipelined_vector_adder.sv
// tb/tb_pipelined_vector_adder.sv - directed self-checking bench for pipelined_vector_adder
module tb_pipelined_vector_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_carry;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_carry;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] va[8];
  logic [31:0] vb[8];
  logic [31:0] vexp[8];

  pipelined_vector_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated beat: checks exact latency, result, and that the bubble behind it holds out_sum.
  task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] cin, input logic [1:0] mode,
                          input logic [31:0] exp_sum, input logic [3:0] exp_carry);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_carry = cin;
    in_mode  = mode;
    #1;
    check_eq({tag, "_rdy"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (STAGES - 1) begin
      @(negedge clk);
      check_eq({tag, "_early"}, out_valid, 0);
    end
    @(negedge clk);
    check_eq({tag, "_vld"}, out_valid, 1);
    check_eq({tag, "_sum"}, out_sum, exp_sum);
    check_eq({tag, "_cout"}, out_carry, exp_carry);
    @(negedge clk);
    check_eq({tag, "_bubble"}, out_valid, 0);
    check_eq({tag, "_held"}, out_sum, exp_sum);
  endtask

  // Streams n beats from va/vb (mode 00), out_ready low for stall_len cycles from stall_at.
  task automatic run_stream(input string tag, input int n, input int stall_at, input int stall_len);
    int sent = 0;
    int rcvd = 0;
    int idx;
    for (int cyc = 0; cyc < n + STAGES + stall_len + 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (sent < n) begin
        in_valid = 1'b1;
        in_a     = va[sent];
        in_b     = vb[sent];
        in_carry = 4'b0000;
        in_mode  = 2'b00;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      idx = (rcvd < n) ? rcvd : n - 1;
      if (out_valid && !out_ready) begin
        check_eq({tag, "_stall_rdy"}, in_ready, 0);
        check_eq({tag, "_hold"}, out_sum, vexp[idx]);
      end else if (out_valid) begin
        check_eq({tag, "_sum"}, out_sum, vexp[idx]);
        if (stall_len == 0) check_eq({tag, "_cyc"}, cyc, STAGES + rcvd);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq({tag, "_count"}, rcvd, n);
    check_eq({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_carry  = 4'b0000;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_vld", out_valid, 0);
    check_eq("rst_sum", out_sum, 0);
    check_eq("rst_cout", out_carry, 0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_rdy", in_ready, 1);

    send_one("full_ripple", 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 2'b00, 32'h0000_0000, 4'b0001);
    send_one("lanes4",      32'h7F80_FF01, 32'h0180_01FF, 4'b0100, 2'b10, 32'h8001_0000, 4'b0111);
    send_one("lanes2",      32'h0000_FFFF, 32'h0000_0001, 4'b0000, 2'b01, 32'h0000_0000, 4'b0001);
    send_one("mode11",      32'h0000_FFFF, 32'h0000_0001, 4'b0000, 2'b11, 32'h0001_0000, 4'b0000);
    send_one("cin_lane0",   32'h8000_0000, 32'h8000_0000, 4'b1111, 2'b00, 32'h0000_0001, 4'b0001);
    send_one("lanes4_cin",  32'hFFFF_FFFF, 32'h0000_0000, 4'b1010, 2'b10, 32'h00FF_00FF, 4'b1010);

    for (int i = 0; i < 8; i++) begin
      va[i]   = 32'(i);
      vb[i]   = 32'(i);
      vexp[i] = 32'(2 * i);
    end
    run_stream("b2b", 8, 0, 0);

    for (int k = 0; k < 6; k++) begin
      va[k]   = 32'h1000_0001 + 32'(k);
      vb[k]   = 32'hF000_0000;
      vexp[k] = 32'h0000_0001 + 32'(k);
    end
    run_stream("bp", 6, 5, 3);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 32'h0000_00A0 + 32'(k);
      in_b     = 32'h0000_0000;
      in_carry = 4'b0000;
      in_mode  = 2'b00;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_pre", out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_vld", out_valid, 0);
    check_eq("midrst_sum", out_sum, 0);
    check_eq("midrst_cout", out_carry, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_rdy", in_ready, 1);
    send_one("post_rst", 32'h1234_5678, 32'h1111_1111, 4'b0000, 2'b00, 32'h2345_6789, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
